// File: rtl/temp_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// temp_ctrl_pkg: shared state encoding and helpers for temp_bram_ctrl.
// Rev 1.0
// ==========================================================================
package temp_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_CLR   = 2'd3
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_OCC_W = $clog2(SKID_DEPTH + 1);

  // A zero or oversized layer length selects the full buffer.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/temp_ctrl_skid.sv
`default_nettype none
// ==========================================================================
// temp_ctrl_skid: 2-entry FIFO holding BRAM read data the consumer has not taken.
// Rev 1.0
// ==========================================================================
module temp_ctrl_skid
  import temp_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  head_valid_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [SKID_OCC_W-1:0] occ_o
);

  localparam int PTR_W = $clog2(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [SKID_OCC_W-1:0] occ_q, occ_d;
  logic                  push_ok, pop_ok;

  assign push_ok      = push_i && (occ_q != SKID_OCC_W'(SKID_DEPTH));
  assign pop_ok       = pop_i && (occ_q != '0);
  assign head_valid_o = (occ_q != '0);
  assign head_data_o  = mem_q[rd_ptr_q];
  assign occ_o        = occ_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      occ_d = occ_q + SKID_OCC_W'(push_ok) - SKID_OCC_W'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/temp_bram_ctrl.sv
`default_nettype none
// ==========================================================================
// temp_bram_ctrl: fill/drain sequencer for the layer temp BRAM.
// Optional feature macro: TEMP_CTRL_AUTOCLR_EN (clear pulse after drain/abort). Rev 1.0
// ==========================================================================
module temp_bram_ctrl
  import temp_ctrl_pkg::*;
#(
  parameter int MAC_CNT    = 128,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(MAC_CNT)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   cfg_len_i,
  input  logic                  abort_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  wr_temp_en,
  output logic [ADDR_WIDTH-1:0] temp_wr_addr,
  output logic                  rd_temp_en,
  output logic [ADDR_WIDTH-1:0] temp_rd_addr,
  output logic                  clear,
  output logic [DATA_WIDTH-1:0] bram_wdata_o,
  input  logic [DATA_WIDTH-1:0] bram_rdata_i
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             in_flight_q, in_flight_d;

  logic                  skid_push, skid_pop, skid_flush, skid_valid, pop;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [SKID_OCC_W-1:0] skid_occ;
  logic [2:0]            level;

  temp_ctrl_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .flush_i      (skid_flush),
    .push_i       (skid_push),
    .push_data_i  (bram_rdata_i),
    .pop_i        (skid_pop),
    .head_valid_o (skid_valid),
    .head_data_o  (skid_data),
    .occ_o        (skid_occ)
  );

  assign busy_o = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    acc_cnt_d    = acc_cnt_q;
    in_flight_d  = 1'b0;
    s_ready_o    = 1'b0;
    wr_temp_en   = 1'b0;
    temp_wr_addr = '0;
    bram_wdata_o = '0;
    rd_temp_en   = 1'b0;
    temp_rd_addr = '0;
    clear        = 1'b0;
    m_valid_o    = 1'b0;
    m_data_o     = '0;
    done_o       = 1'b0;
    pop          = 1'b0;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
    skid_flush   = 1'b0;
    level        = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d     = CNT_W'(eff_len(32'(cfg_len_i), MAC_CNT));
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          acc_cnt_d = '0;
          state_d   = S_FILL;
        end
      end

      S_FILL: begin
        s_ready_o    = 1'b1;
        wr_temp_en   = s_valid_i;
        bram_wdata_o = s_data_i;
        if (s_valid_i) begin
          temp_wr_addr = wr_cnt_q[ADDR_WIDTH-1:0];
          wr_cnt_d     = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == len_q - CNT_W'(1)) begin
            wr_cnt_d = '0;
            state_d  = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Returning read data bypasses the skid when it is empty, so the
        // first beat is visible one cycle after the first read strobe.
        m_valid_o = skid_valid | in_flight_q;
        m_data_o  = skid_valid ? skid_data : bram_rdata_i;
        pop       = m_valid_o & m_ready_i;
        skid_pop  = pop & skid_valid;
        skid_push = in_flight_q & ~(pop & ~skid_valid);
        level     = 3'(skid_occ) + 3'(in_flight_q) - 3'(pop);
        if ((level < 3'(SKID_DEPTH)) && (rd_cnt_q < len_q)) begin
          rd_temp_en   = 1'b1;
          temp_rd_addr = rd_cnt_q[ADDR_WIDTH-1:0];
          rd_cnt_d     = rd_cnt_q + CNT_W'(1);
          in_flight_d  = 1'b1;
        end
        if (pop) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == len_q - CNT_W'(1)) begin
            done_o     = 1'b1;
            acc_cnt_d  = '0;
            rd_cnt_d   = '0;
            skid_flush = 1'b1;
`ifdef TEMP_CTRL_AUTOCLR_EN
            state_d    = S_CLR;
`else
            state_d    = S_IDLE;
`endif
          end
        end
      end

`ifdef TEMP_CTRL_AUTOCLR_EN
      S_CLR: begin
        clear   = 1'b1;
        state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      done_o      = 1'b0;
      skid_flush  = 1'b1;
      skid_push   = 1'b0;
      in_flight_d = 1'b0;
      wr_cnt_d    = '0;
      rd_cnt_d    = '0;
      acc_cnt_d   = '0;
`ifdef TEMP_CTRL_AUTOCLR_EN
      state_d     = S_CLR;
`else
      state_d     = S_IDLE;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      acc_cnt_q   <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      in_flight_q <= in_flight_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_temp_bram_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_temp_bram_ctrl: table-driven fill/drain checks against a temp BRAM model.
// Rev 1.0
// ==========================================================================
module tb_temp_bram_ctrl;

  localparam int MAC_CNT = 128;
  localparam int DW      = 8;
  localparam int AW      = 7;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW:0]   cfg_len_i = '0;
  logic          abort_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ready_o, m_valid_o, m_ready_i, busy_o, done_o;
  logic [DW-1:0] m_data_o, bram_wdata_o, bram_rdata_i;
  logic          wr_temp_en, rd_temp_en, clear;
  logic [AW-1:0] temp_wr_addr, temp_rd_addr;

  int checks = 0;
  int failures = 0;
  int clear_total = 0;

  always #5 clk = ~clk;

  temp_bram_ctrl #(.MAC_CNT(MAC_CNT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .cfg_len_i(cfg_len_i),
    .abort_i(abort_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i), .busy_o(busy_o),
    .done_o(done_o), .wr_temp_en(wr_temp_en), .temp_wr_addr(temp_wr_addr),
    .rd_temp_en(rd_temp_en), .temp_rd_addr(temp_rd_addr), .clear(clear),
    .bram_wdata_o(bram_wdata_o), .bram_rdata_i(bram_rdata_i)
  );

  // Temp BRAM model: priority wr > rd > clear, read data zero when not reading.
  logic [DW-1:0] mem [MAC_CNT];
  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      bram_rdata_i <= '0;
    end else begin
      bram_rdata_i <= '0;
      if (wr_temp_en) mem[temp_wr_addr] <= bram_wdata_o;
      else if (rd_temp_en) bram_rdata_i <= mem[temp_rd_addr];
      else if (clear) for (int i = 0; i < MAC_CNT; i++) mem[i] <= '0;
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rstn_i) begin
      if (clear) clear_total++;
      a_excl: assert (!((wr_temp_en && rd_temp_en) || (wr_temp_en && clear) || (rd_temp_en && clear)))
      else begin
        failures++;
        $display("FAIL strobe_exclusive wr=%0b rd=%0b clear=%0b required at most one", wr_temp_en, rd_temp_en, clear);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int base, input int step, input int i);
    return DW'(base + step * i);
  endfunction

  typedef struct {
    int len;
    int eff;
    int base;
    int step;
    int mode;   // 0: m_ready held high, 1: pattern 1,0,0 repeating
    bit poke;   // pulse start_i while draining
  } vec_t;

  task automatic run_layer(input vec_t v);
    int widx = 0, ridx = 0, last_wr = -1, first_mv = -1, last_acc = -1;
    int dones = 0, maxaddr = -1, end_cyc = -1, clr_cyc = -1, bad = 0;
    bit prev_hold = 0;
    logic [DW-1:0] prev_data = '0;
    @(negedge clk);
    start_i = 1'b1;
    cfg_len_i = (AW+1)'(v.len);
    #1;
    chk("idle_before_start", int'(busy_o), 0);
    @(negedge clk);
    start_i = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      s_valid_i = (widx < v.eff);
      s_data_i  = exp_data(v.base, v.step, widx);
      m_ready_i = (v.mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      start_i   = v.poke && (first_mv >= 0);
      cfg_len_i = (AW+1)'(2);
      #1;
      if (!busy_o) begin
        end_cyc = cyc;
        break;
      end
      if (wr_temp_en) begin
        chk("wr_addr", int'(temp_wr_addr), widx);
        widx++;
        last_wr = cyc;
      end
      if (rd_temp_en && int'(temp_rd_addr) > maxaddr) maxaddr = int'(temp_rd_addr);
      if (prev_hold) begin
        chk("hold_valid", int'(m_valid_o), 1);
        chk("hold_data", int'(m_data_o), int'(prev_data));
      end
      prev_hold = m_valid_o && !m_ready_i;
      prev_data = m_data_o;
      if (m_valid_o) begin
        if (first_mv < 0) first_mv = cyc;
        if (m_ready_i) begin
          chk("beat_data", int'(m_data_o), int'(exp_data(v.base, v.step, ridx)));
          ridx++;
          last_acc = cyc;
        end
      end
      if (done_o) begin
        dones++;
        chk("done_at_last_beat", ridx, v.eff);
      end
      if (clear && clr_cyc < 0) clr_cyc = cyc;
      @(negedge clk);
    end
    start_i = 1'b0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    chk("layer_terminated", int'(end_cyc >= 0), 1);
    chk("writes", widx, v.eff);
    chk("beats", ridx, v.eff);
    chk("done_pulses", dones, 1);
    chk("max_rd_addr", maxaddr, v.eff - 1);
    chk("first_valid_latency", first_mv, last_wr + 2);
    if (v.mode == 0) chk("drain_throughput", last_acc, first_mv + v.eff - 1);
`ifdef TEMP_CTRL_AUTOCLR_EN
    chk("clear_cycle", clr_cyc, last_acc + 1);
    chk("idle_after_clr", end_cyc, last_acc + 2);
    for (int i = 0; i < v.eff; i++) if (mem[i] != '0) bad++;
    chk("mem_cleared", bad, 0);
`else
    chk("idle_after_drain", end_cyc, last_acc + 1);
    for (int i = 0; i < v.eff; i++) if (mem[i] != exp_data(v.base, v.step, i)) bad++;
    chk("mem_retained", bad, 0);
`endif
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{len: 4,   eff: 4,   base: 'h11, step: 'h11, mode: 0, poke: 0};
    vecs[1] = '{len: 0,   eff: 128, base: 'h05, step: 3,    mode: 0, poke: 0};
    vecs[2] = '{len: 6,   eff: 6,   base: 'hA0, step: 1,    mode: 1, poke: 0};
    vecs[3] = '{len: 1,   eff: 1,   base: 'h5A, step: 0,    mode: 0, poke: 0};
    vecs[4] = '{len: 5,   eff: 5,   base: 'h30, step: 2,    mode: 0, poke: 1};
    vecs[5] = '{len: 200, eff: 128, base: 'h01, step: 5,    mode: 1, poke: 0};
    vecs[6] = '{len: 128, eff: 128, base: 'hC3, step: 7,    mode: 1, poke: 1};
    m_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({busy_o, s_ready_o, m_valid_o, done_o, wr_temp_en, rd_temp_en, clear}), 0);
    rstn_i = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_outputs", int'({busy_o, s_ready_o, m_valid_o, done_o, wr_temp_en, rd_temp_en, clear}), 0);
    chk("post_reset_addrs", int'({temp_wr_addr, temp_rd_addr}), 0);

    for (int t = 0; t < 7; t++) run_layer(vecs[t]);

    // Abort after two of four writes.
    @(negedge clk);
    start_i = 1'b1;
    cfg_len_i = (AW+1)'(4);
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid_i = 1'b1;
      s_data_i = DW'(8'h70 + i);
      #1;
      chk("abort_pre_wr", int'(wr_temp_en), 1);
      chk("abort_pre_addr", int'(temp_wr_addr), i);
      @(negedge clk);
    end
    s_valid_i = 1'b0;
    abort_i = 1'b1;
    #1;
    chk("abort_no_done", int'(done_o), 0);
    @(negedge clk);
    abort_i = 1'b0;
    #1;
`ifdef TEMP_CTRL_AUTOCLR_EN
    chk("abort_clear", int'(clear), 1);
    chk("abort_busy_clr", int'(busy_o), 1);
    @(negedge clk);
    #1;
`endif
    chk("abort_idle", int'(busy_o), 0);
    chk("abort_s_ready", int'(s_ready_o), 0);
    chk("abort_done_low", int'(done_o), 0);
    chk("abort_clear_low", int'(clear), 0);

    run_layer('{len: 3, eff: 3, base: 'h90, step: 'h10, mode: 0, poke: 0});

`ifndef TEMP_CTRL_AUTOCLR_EN
    chk("clear_never", clear_total, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
